// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: streams a word-oriented bitstream into a serial
// configuration-flop chain, optionally followed by a readback-verify pass in
// which the host resends the same bitstream and the chain tail is compared
// against the head bit by bit.
//
// Ports
//   prog_clk       configuration clock, rising edge
//   pReset         synchronous active-high reset
//   start          begin a load (accepted in IDLE only)
//   verify_en      request a verify pass, latched when start is accepted
//   cfg_data       bitstream word, bit 0 shifted first
//   cfg_valid      cfg_data valid
//   cfg_ready      word buffer empty during LOAD/VERIFY
//   ccff_head      serial data to chain head
//   ccff_shift_en  chain shifts on this edge
//   ccff_tail      serial data from chain tail
//   busy           LOAD or VERIFY in progress
//   done           one-cycle completion pulse
//   error          sticky verify-mismatch flag
//   mismatch_cnt   saturating verify mismatch count
module ccff_chain_loader #(
    parameter int unsigned CHAIN_LEN = 40,
    parameter int unsigned WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              verify_en,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [15:0]       mismatch_cnt
);

    localparam int unsigned NB_W  = $clog2(WORD_W + 1);
    localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        VERIFY = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [WORD_W-1:0] r_buf, w_buf_nxt;
    logic [NB_W-1:0]   r_nbits, w_nbits_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              r_verify, w_verify_nxt;
    logic              r_error, w_error_nxt;
    logic [15:0]       r_mcnt, w_mcnt_nxt;

    logic r_cfg_ready, r_head, r_shift_en, r_busy, r_done;
    logic w_cfg_ready_nxt, w_head_nxt, w_shift_en_nxt, w_busy_nxt, w_done_nxt;

    logic w_accept;
    logic w_shift;

    // r_cfg_ready mirrors (busy && buffer empty), r_shift_en mirrors (buffer non-empty)
    assign w_accept = r_cfg_ready & cfg_valid;
    assign w_shift  = r_shift_en;

    // Next-state, datapath and next-output logic
    always_comb begin
        w_state_nxt  = r_state;
        w_buf_nxt    = r_buf;
        w_nbits_nxt  = r_nbits;
        w_cnt_nxt    = r_cnt;
        w_verify_nxt = r_verify;
        w_error_nxt  = r_error;
        w_mcnt_nxt   = r_mcnt;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt  = LOAD;
                    w_cnt_nxt    = '0;
                    w_nbits_nxt  = '0;
                    w_error_nxt  = 1'b0;
                    w_mcnt_nxt   = '0;
                    w_verify_nxt = verify_en;
                end
            end
            LOAD, VERIFY: begin
                if (w_accept) begin
                    w_buf_nxt   = cfg_data;
                    w_nbits_nxt = NB_W'(WORD_W);
                end else if (w_shift) begin
                    if (r_state == VERIFY && ccff_tail != r_head) begin
                        w_error_nxt = 1'b1;
                        if (r_mcnt != 16'hFFFF) begin
                            w_mcnt_nxt = r_mcnt + 16'd1;
                        end
                    end
                    // Last chain bit: drop any leftover buffer bits and end the pass
                    if (r_cnt == CNT_W'(CHAIN_LEN - 1)) begin
                        w_cnt_nxt   = '0;
                        w_nbits_nxt = '0;
                        w_buf_nxt   = '0;
                        if (r_state == LOAD && r_verify) begin
                            w_state_nxt = VERIFY;
                        end else begin
                            w_state_nxt = DONE;
                        end
                    end else begin
                        w_cnt_nxt   = CNT_W'(r_cnt + CNT_W'(1));
                        w_nbits_nxt = r_nbits - NB_W'(1);
                        w_buf_nxt   = r_buf >> 1;
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Outputs are registered from the next-state view
        w_busy_nxt      = (w_state_nxt == LOAD) || (w_state_nxt == VERIFY);
        w_done_nxt      = (w_state_nxt == DONE);
        w_cfg_ready_nxt = w_busy_nxt && (w_nbits_nxt == '0);
        w_shift_en_nxt  = (w_nbits_nxt != '0);
        w_head_nxt      = w_shift_en_nxt & w_buf_nxt[0];
    end

    // State and output registers
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            r_state     <= IDLE;
            r_buf       <= '0;
            r_nbits     <= '0;
            r_cnt       <= '0;
            r_verify    <= 1'b0;
            r_error     <= 1'b0;
            r_mcnt      <= '0;
            r_cfg_ready <= 1'b0;
            r_head      <= 1'b0;
            r_shift_en  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_buf       <= w_buf_nxt;
            r_nbits     <= w_nbits_nxt;
            r_cnt       <= w_cnt_nxt;
            r_verify    <= w_verify_nxt;
            r_error     <= w_error_nxt;
            r_mcnt      <= w_mcnt_nxt;
            r_cfg_ready <= w_cfg_ready_nxt;
            r_head      <= w_head_nxt;
            r_shift_en  <= w_shift_en_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign cfg_ready     = r_cfg_ready;
    assign ccff_head     = r_head;
    assign ccff_shift_en = r_shift_en;
    assign busy          = r_busy;
    assign done          = r_done;
    assign error         = r_error;
    assign mismatch_cnt  = r_mcnt;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Testbench for ccff_chain_loader: 12-flop chain model on the serial port,
// scenario tasks checked against a bitstream-level reference model.
module tb_ccff_chain_loader;

    localparam int CL = 12;
    localparam int WW = 8;
    localparam int NW = (CL + WW - 1) / WW;

    logic        prog_clk = 1'b0;
    logic        pReset, start, verify_en, cfg_valid;
    logic [7:0]  cfg_data;
    logic        cfg_ready, ccff_head, ccff_shift_en, ccff_tail;
    logic        busy, done, error;
    logic [15:0] mismatch_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 prog_clk = ~prog_clk;

    ccff_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
        .prog_clk      (prog_clk),
        .pReset        (pReset),
        .start         (start),
        .verify_en     (verify_en),
        .cfg_data      (cfg_data),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .ccff_head     (ccff_head),
        .ccff_shift_en (ccff_shift_en),
        .ccff_tail     (ccff_tail),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .mismatch_cnt  (mismatch_cnt)
    );

    // Chain model plus shift / done monitor
    logic [CL-1:0] chain = '0;
    logic [CL-1:0] fmask = '0;
    int            shift_idx = 0;
    int            done_cnt = 0;
    bit            mon_clr = 1'b0;
    bit            got_q[$];

    always @(posedge prog_clk) begin
        if (ccff_shift_en) chain <= {ccff_head, chain[CL-1:1]};
        if (mon_clr) begin
            shift_idx <= 0;
            done_cnt  <= 0;
            got_q.delete();
        end else begin
            if (ccff_shift_en) begin
                shift_idx <= shift_idx + 1;
                got_q.push_back(ccff_head);
            end
            if (done) done_cnt <= done_cnt + 1;
        end
    end

    // Fault injection: invert the tail on selected verify-pass shifts
    assign ccff_tail = chain[0] ^ ((shift_idx >= CL && shift_idx < 2*CL) ?
                                   fmask[4'(shift_idx - CL)] : 1'b0);

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic test_reset();
        pReset = 1'b1; start = 1'b1; verify_en = 1'b1;
        cfg_valid = 1'b1; cfg_data = 8'hFF;
        tick();
        n_checks++;
        if ({cfg_ready, ccff_head, ccff_shift_en, busy, done, error} !== 6'b0 ||
            mismatch_cnt !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b head=%b sh=%b busy=%b done=%b err=%b cnt=%0d, want all 0",
                     cfg_ready, ccff_head, ccff_shift_en, busy, done, error, mismatch_cnt);
        end
        tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_overrides_start: busy=%b want 0", busy);
        end
        pReset = 1'b0; start = 1'b0; cfg_valid = 1'b0; verify_en = 1'b0;
        tick();
        n_checks++;
        if (busy !== 1'b0 || cfg_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%b rdy=%b want 0 0", busy, cfg_ready);
        end
    endtask

    // Wait for buffer-empty, hold off for 'gap' cycles, then hand over one word
    task automatic send_word(input logic [7:0] w, input int gap, input bit poke);
        cfg_valid = 1'b0;
        for (int k = 0; k < 64 && !cfg_ready; k++) tick();
        n_checks++;
        if (cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_timeout: cfg_ready=%b want 1 within 64 cycles", cfg_ready);
        end
        for (int g = 0; g < gap; g++) begin
            n_checks++;
            if (ccff_shift_en !== 1'b0 || ccff_head !== 1'b0 || cfg_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL gap_idle: sh=%b head=%b rdy=%b want 0 0 1",
                         ccff_shift_en, ccff_head, cfg_ready);
            end
            if (poke && g == 0) begin start = 1'b1; verify_en = 1'b1; end
            tick();
            start = 1'b0; verify_en = 1'b0;
        end
        cfg_data  = w;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        cfg_data  = 8'($urandom);
        n_checks++;
        if (ccff_shift_en !== 1'b1 || cfg_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL accept_then_shift: sh=%b rdy=%b want 1 0", ccff_shift_en, cfg_ready);
        end
    endtask

    // One full job: start, one or two passes, then check against the model
    task automatic run_job(input logic [7:0] w[NW], input bit v, input logic [CL-1:0] mask,
                           input int gmin, input int gmax, input bit poke, input string tag);
        logic [CL-1:0] pass_bits;
        bit            exp_q[$];
        int            exp_mis;
        bit            seen;
        int            passes;

        for (int i = 0; i < CL; i++) pass_bits[i] = w[i / WW][i % WW];
        passes  = v ? 2 : 1;
        for (int p = 0; p < passes; p++)
            for (int i = 0; i < CL; i++) exp_q.push_back(pass_bits[i]);
        exp_mis = v ? $countones(mask) : 0;
        fmask   = v ? mask : '0;

        start = 1'b1; verify_en = v; mon_clr = 1'b1;
        tick();
        start = 1'b0; verify_en = 1'b0; mon_clr = 1'b0;

        for (int p = 0; p < passes; p++)
            for (int i = 0; i < NW; i++)
                send_word(w[i], $urandom_range(gmax, gmin), poke && i == 1);

        seen = done;
        for (int k = 0; k < 64 && !seen; k++) begin
            tick();
            seen = done;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s done_timeout: done never 1", tag);
        end
        n_checks++;
        if (error !== (exp_mis != 0) || mismatch_cnt !== 16'(exp_mis)) begin
            n_fail++;
            $display("FAIL %s verify_result: err=%b cnt=%0d want err=%b cnt=%0d",
                     tag, error, mismatch_cnt, exp_mis != 0, exp_mis);
        end
        repeat (3) tick();
        n_checks++;
        if (done_cnt !== 1 || busy !== 1'b0 || cfg_ready !== 1'b0 || ccff_shift_en !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle_after: done_cnt=%0d busy=%b rdy=%b sh=%b want 1 0 0 0",
                     tag, done_cnt, busy, cfg_ready, ccff_shift_en);
        end
        n_checks++;
        if (error !== (exp_mis != 0) || mismatch_cnt !== 16'(exp_mis)) begin
            n_fail++;
            $display("FAIL %s held_in_idle: err=%b cnt=%0d want err=%b cnt=%0d",
                     tag, error, mismatch_cnt, exp_mis != 0, exp_mis);
        end
        n_checks++;
        if (got_q != exp_q) begin
            n_fail++;
            $display("FAIL %s head_sequence: got %p want %p", tag, got_q, exp_q);
        end
        n_checks++;
        if (chain !== pass_bits) begin
            n_fail++;
            $display("FAIL %s chain_contents: got %h want %h", tag, chain, pass_bits);
        end
    endtask

    task automatic test_load_only();
        logic [7:0] w[NW] = '{8'hA5, 8'h03};
        run_job(w, 1'b0, '0, 0, 0, 1'b0, "load_only");
    endtask

    task automatic test_load_verify();
        logic [7:0] w[NW] = '{8'hA5, 8'h03};
        run_job(w, 1'b1, '0, 0, 0, 1'b0, "load_verify");
        n_checks++;
        if (chain !== 12'h3A5) begin
            n_fail++;
            $display("FAIL chain_3a5: got %h want 3a5", chain);
        end
    endtask

    task automatic test_fault();
        logic [7:0] w[NW] = '{8'hA5, 8'h03};
        run_job(w, 1'b1, 12'(1 << 5), 0, 0, 1'b0, "fault_6th");
    endtask

    task automatic test_backpressure();
        logic [7:0] w[NW] = '{8'h5C, 8'h0E};
        run_job(w, 1'b0, '0, 3, 3, 1'b1, "backpressure");
        run_job(w, 1'b1, 12'h801, 3, 3, 1'b1, "backpressure_verify");
    endtask

    task automatic test_reset_mid_load();
        logic [7:0] w[NW] = '{8'hA5, 8'h03};
        int s0;
        start = 1'b1; verify_en = 1'b0; mon_clr = 1'b1;
        tick();
        start = 1'b0; mon_clr = 1'b0;
        send_word(8'hA5, 0, 1'b0);
        for (int k = 0; k < 32 && shift_idx < 5; k++) tick();
        pReset = 1'b1;
        tick();
        pReset = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || ccff_shift_en !== 1'b0 || cfg_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_abort: busy=%b sh=%b rdy=%b want 0 0 0",
                     busy, ccff_shift_en, cfg_ready);
        end
        s0 = shift_idx;
        repeat (4) tick();
        n_checks++;
        if (shift_idx !== s0) begin
            n_fail++;
            $display("FAIL mid_reset_no_shift: shifts=%0d want %0d", shift_idx, s0);
        end
        run_job(w, 1'b0, '0, 0, 1, 1'b0, "after_reset");
    endtask

    task automatic test_random();
        logic [7:0]    w[NW];
        bit            v;
        logic [CL-1:0] m;
        for (int it = 0; it < 16; it++) begin
            for (int i = 0; i < NW; i++) w[i] = 8'($urandom);
            v = 1'($urandom);
            m = (v && it % 2 == 0) ? CL'($urandom) : '0;
            run_job(w, v, m, 0, 3, 1'($urandom), "random");
        end
    endtask

    initial begin
        pReset = 1'b0; start = 1'b0; verify_en = 1'b0;
        cfg_valid = 1'b0; cfg_data = '0;
        #2;
        test_reset();
        test_load_only();
        test_load_verify();
        test_fault();
        test_backpressure();
        test_reset_mid_load();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
